ram_1r1w: RTL and testbench
===========================

RAM_1R1W -- requirements
Module: ram_1r1w

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 s_write_addr  input  ADDR_WIDTH  write address.
REQ-006 s_write_req  input  1  write enable; 1 = write this cycle.
REQ-007 s_write_data  input  DATA_WIDTH  write data.
REQ-008 s_read_addr  input  ADDR_WIDTH  read address.
REQ-009 s_read_req  input  1  read enable; 1 = read this cycle.
REQ-010 s_read_data  output  DATA_WIDTH  registered read data.

Function
REQ-011 Storage SHALL be 2**ADDR_WIDTH words of DATA_WIDTH bits, one write port and one read port, both synchronous to clk.
REQ-012 Write: when s_write_req=1 at a rising edge, mem[s_write_addr] SHALL take s_write_data; when s_write_req=0 no entry changes.
REQ-013 Read: when s_read_req=1 at edge N, s_read_data SHALL present mem[s_read_addr] after edge N, valid in cycle N+1 (1-cycle latency).
REQ-014 When s_read_req=0, s_read_data SHALL hold its previous value indefinitely.
REQ-015 Read and write ports SHALL operate independently in the same cycle at any address pair.
REQ-016 Same-address read and write in one cycle (macro absent): s_read_data SHALL return the old contents (read-first); the new data is visible to reads from the next cycle on.
REQ-017 Address SHALL be used unsigned and in full; no out-of-range case exists; no wrap logic required.
REQ-018 No handshake or backpressure: every request SHALL complete in one cycle; back-to-back requests every cycle SHALL be supported.
REQ-019 s_read_data SHALL be driven solely from the output register; no combinational path from inputs to s_read_data.

Reset
REQ-020 While reset=1 at a rising edge, s_read_data SHALL become 0 regardless of s_read_req.
REQ-021 Reset SHALL NOT clear memory contents; entries written before reset SHALL stay readable after it.
REQ-022 A write with s_write_req=1 while reset=1 SHALL still be performed.
REQ-023 Reads in the first cycle after reset deassertion SHALL behave per REQ-013.

Configuration
REQ-024 Macro RAM_WR_BYPASS_EN: when defined, a same-address read and write in one cycle SHALL return s_write_data on s_read_data (write-first); when undefined, behaviour SHALL be read-first per REQ-016.
REQ-025 All other behaviour SHALL be identical with and without RAM_WR_BYPASS_EN.

Verification (ADDR_WIDTH=5, DATA_WIDTH=16)
REQ-026 Reset held 2 cycles -> s_read_data=0x0000; write addr 3 = 0xBEEF, next cycle read addr 3 -> s_read_data=0xBEEF one cycle after the read request.
REQ-027 Write addr 0..31 with data 0x1000+addr on consecutive cycles, then read 31..0 back-to-back -> each value returned at 1-cycle latency, no bubbles.
REQ-028 Read addr 5 (=0x0055), then hold s_read_req=0 for 4 cycles while writing addr 5 = 0x00AA -> s_read_data stays 0x0055.
REQ-029 Addr 7 holds 0x1111; same cycle write addr 7 = 0x2222 and read addr 7 -> 0x1111 without macro, 0x2222 with RAM_WR_BYPASS_EN; read addr 7 next cycle -> 0x2222 in both builds.
REQ-030 Addr 9 holds 0x0009; assert reset 1 cycle -> s_read_data=0x0000; read addr 9 after reset -> 0x0009 (contents retained).
REQ-031 Simultaneous write addr 2 = 0x0BAD and read addr 4 (=0x0044) -> s_read_data=0x0044; read addr 2 next cycle -> 0x0BAD.

Source files
------------

// File: rtl/ram_1r1w.sv
// ram_1r1w -- simple dual-port RAM: one synchronous write port, one
// synchronous read port with a registered output (1-cycle read latency).
//
// Optional feature macro:
//   RAM_WR_BYPASS_EN  When defined, a same-cycle read and write to the same
//                     address returns the write data (write-first).
//                     When undefined, the read returns the old contents
//                     (read-first).
//
// The reset clears only the read data register. Memory contents survive a
// reset, and writes issued while reset is high are still performed.

module ram_1r1w #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_write_addr,
  input  logic                  s_write_req,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  input  logic [ADDR_WIDTH-1:0] s_read_addr,
  input  logic                  s_read_req,
  output logic [DATA_WIDTH-1:0] s_read_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] read_data_r;
  logic [DATA_WIDTH-1:0] read_word_s;

  // Write port. The memory has no reset, so writes proceed even while reset is high.
  always_ff @(posedge clk) begin
    if (s_write_req) begin
      mem_r[s_write_addr] <= s_write_data;
    end
  end

  // Select the word to capture: the array word, or the incoming write data on a same-address collision when bypass is built in.
  always_comb begin
    read_word_s = mem_r[s_read_addr];
`ifdef RAM_WR_BYPASS_EN
    if (s_write_req && (s_write_addr == s_read_addr)) begin
      read_word_s = s_write_data;
    end else begin
      read_word_s = mem_r[s_read_addr];
    end
`endif
  end

  // Read data register: cleared by reset, loaded on a read request, and held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_r <= {DATA_WIDTH{1'b0}};
    end else if (s_read_req) begin
      read_data_r <= read_word_s;
    end else begin
      read_data_r <= read_data_r;
    end
  end

  assign s_read_data = read_data_r;

endmodule

// File: tb/tb_ram_1r1w.sv
// tb_ram_1r1w -- directed, table-driven bench for ram_1r1w (ADDR_WIDTH=5,
// DATA_WIDTH=16). Each step drives one cycle of inputs and optionally
// compares s_read_data just after the following rising edge against a
// hand-computed value. Define RAM_WR_BYPASS_EN to check the write-first build.

module tb_ram_1r1w;

  localparam int AW = 5;
  localparam int DW = 16;

`ifdef RAM_WR_BYPASS_EN
  localparam logic [DW-1:0] COLLIDE_EXP = 16'h2222;
`else
  localparam logic [DW-1:0] COLLIDE_EXP = 16'h1111;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] s_write_addr;
  logic          s_write_req;
  logic [DW-1:0] s_write_data;
  logic [AW-1:0] s_read_addr;
  logic          s_read_req;
  logic [DW-1:0] s_read_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rd;
    logic [AW-1:0] ra;
    logic          chk;
    logic [DW-1:0] exp;
    string         name;
  } vec_t;

  vec_t vecs[$];

  ram_1r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_write_addr (s_write_addr),
    .s_write_req  (s_write_req),
    .s_write_data (s_write_data),
    .s_read_addr  (s_read_addr),
    .s_read_req   (s_read_req),
    .s_read_data  (s_read_data)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic wr, input int wa,
                              input int wd, input logic rd, input int ra,
                              input logic chk, input int exp, input string name);
    vec_t v;
    v.rst  = rst;
    v.wr   = wr;
    v.wa   = AW'(wa);
    v.wd   = DW'(wd);
    v.rd   = rd;
    v.ra   = AW'(ra);
    v.chk  = chk;
    v.exp  = DW'(exp);
    v.name = name;
    return v;
  endfunction

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic step(input vec_t v);
    reset        = v.rst;
    s_write_req  = v.wr;
    s_write_addr = v.wa;
    s_write_data = v.wd;
    s_read_req   = v.rd;
    s_read_addr  = v.ra;
    @(posedge clk);
    #1;
    if (v.chk) begin
      checks++;
      if (s_read_data !== v.exp) begin
        errors++;
        $display("FAIL %s: got 0x%04h expected 0x%04h", v.name, s_read_data, v.exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; s_write_req = 1'b0; s_write_addr = '0; s_write_data = '0;
    s_read_req = 1'b0; s_read_addr = '0;

    // Table: basic write/read, full sweep, independent ports.
    vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b1, 0, 1'b1, 16'h0000, "reset_c1"));
    vecs.push_back(mk(1'b1, 1'b0, 0, 0, 1'b1, 0, 1'b1, 16'h0000, "reset_c2"));
    vecs.push_back(mk(1'b0, 1'b1, 3, 16'hBEEF, 1'b0, 0, 1'b1, 16'h0000, "hold_after_reset"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 1'b1, 3, 1'b1, 16'hBEEF, "read_addr3"));
    for (int a = 0; a < 32; a++)
      vecs.push_back(mk(1'b0, 1'b1, a, 16'h1000 + a, 1'b0, 31 - a, 1'b1, 16'hBEEF, "sweep_write_hold"));
    for (int a = 31; a >= 0; a--)
      vecs.push_back(mk(1'b0, 1'b0, 0, 0, 1'b1, a, 1'b1, 16'h1000 + a, "sweep_read"));
    vecs.push_back(mk(1'b0, 1'b1, 4, 16'h0044, 1'b0, 0, 1'b0, 0, "setup_addr4"));
    vecs.push_back(mk(1'b0, 1'b1, 2, 16'h0BAD, 1'b1, 4, 1'b1, 16'h0044, "indep_wr2_rd4"));
    vecs.push_back(mk(1'b0, 1'b0, 0, 0, 1'b1, 2, 1'b1, 16'h0BAD, "read_addr2"));

    foreach (vecs[i]) step(vecs[i]);

    // Hold: output stays while reads are idle, even as the address is rewritten.
    step(mk(1'b0, 1'b1, 5, 16'h0055, 1'b0, 0, 1'b0, 0, "setup_addr5"));
    step(mk(1'b0, 1'b0, 0, 0, 1'b1, 5, 1'b1, 16'h0055, "read_addr5"));
    for (int k = 0; k < 4; k++)
      step(mk(1'b0, 1'b1, 5, 16'h00AA, 1'b0, k, 1'b1, 16'h0055, "hold_no_req"));
    step(mk(1'b0, 1'b0, 0, 0, 1'b1, 5, 1'b1, 16'h00AA, "read_addr5_new"));

    // Same-address collision.
    step(mk(1'b0, 1'b1, 7, 16'h1111, 1'b0, 0, 1'b1, 16'h00AA, "setup_addr7_hold"));
    step(mk(1'b0, 1'b1, 7, 16'h2222, 1'b1, 7, 1'b1, COLLIDE_EXP, "collide_addr7"));
    step(mk(1'b0, 1'b0, 0, 0, 1'b1, 7, 1'b1, 16'h2222, "after_collide_addr7"));

    // Reset keeps memory, clears output, still performs writes.
    step(mk(1'b0, 1'b1, 9, 16'h0009, 1'b0, 0, 1'b0, 0, "setup_addr9"));
    step(mk(1'b0, 1'b0, 0, 0, 1'b1, 9, 1'b1, 16'h0009, "read_addr9_pre"));
    step(mk(1'b1, 1'b1, 10, 16'h0A0A, 1'b1, 9, 1'b1, 16'h0000, "reset_clears_out"));
    step(mk(1'b0, 1'b0, 0, 0, 1'b1, 9, 1'b1, 16'h0009, "retained_addr9"));
    step(mk(1'b0, 1'b0, 0, 0, 1'b1, 10, 1'b1, 16'h0A0A, "write_during_reset"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
